fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction decoder. Generates sequential PCs, issues word requests to instruction memory over a valid/ready handshake, buffers in-order responses in a small FIFO, and presents 32-bit instructions with their PC to decode over a valid/ready handshake. Handles redirects from branch/jump resolution by flushing buffered and in-flight instructions.

---
 rtl/fetch_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Sequential PC generation, credit-limited imem requests, in-order response
// buffering with PC tags, and redirect flush with stale-response dropping.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign_fault
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    // Architectural state
    logic [31:0]      fetch_pc_q;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic [PTR_W-1:0] fifo_rd_q;
    logic [PTR_W-1:0] fifo_wr_q;
    logic [PTR_W-1:0] tag_rd_q;
    logic [PTR_W-1:0] tag_wr_q;
    entry_t           fifo_mem_q [FIFO_DEPTH];
    logic [31:0]      tag_mem_q  [FIFO_DEPTH];
    state_e           state_q;

    // Next-state values
    logic [31:0]      fetch_pc_d;
    logic [CNT_W-1:0] inflight_d;
    logic [CNT_W-1:0] drop_d;
    logic [CNT_W-1:0] fifo_cnt_d;
    logic [PTR_W-1:0] fifo_rd_d;
    logic [PTR_W-1:0] fifo_wr_d;
    logic [PTR_W-1:0] tag_rd_d;
    logic [PTR_W-1:0] tag_wr_d;
    state_e           state_d;

    // Handshake qualifiers
    logic fault_state;
    logic credit_ok;
    logic req_fire;
    logic fifo_push;
    logic fifo_pop;
    logic misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = |redirect_pc[1:0];
`else
    // Low target bits are ignored when the trap is not built in
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign misaligned    = 1'b0;
`endif

    // Request credit: in-flight plus buffered may never exceed the buffer size
    assign credit_ok = (SUM_W'(inflight_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(FIFO_DEPTH);

    assign imem_req_valid = rst_n && !fault_state && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = (fifo_cnt_q != '0) && !fault_state;
    assign inst       = fifo_mem_q[fifo_rd_q].word;
    assign inst_pc    = fifo_mem_q[fifo_rd_q].pc;
    assign fifo_pop   = inst_valid && inst_ready;

    // A response is buffered only if it is not stale and no flush happens this cycle
    assign fifo_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    // Fault state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Fault next-state: only a redirect can enter or leave the fault state
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = misaligned ? ST_FAULT : ST_RUN;
        end
    end

    // Fault outputs decoded from the state register
    always_comb begin
        fault_state = 1'b0;
        if (state_q == ST_FAULT) begin
            fault_state = 1'b1;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_fault = fault_state;
`else
    assign misalign_fault = 1'b0;
`endif

    // Counter, pointer and PC next-state; redirect overrides everything last
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;

        if (req_fire) begin
            inflight_d = inflight_d + CNT_ONE;
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = tag_wr_q + PTR_ONE;
        end

        if (imem_rsp_valid) begin
            inflight_d = inflight_d - CNT_ONE;
            tag_rd_d   = tag_rd_q + PTR_ONE;
            if (drop_q != '0) begin
                drop_d = drop_q - CNT_ONE;
            end
        end

        if (fifo_push) begin
            fifo_wr_d  = fifo_wr_q + PTR_ONE;
            fifo_cnt_d = fifo_cnt_d + CNT_ONE;
        end

        if (fifo_pop) begin
            fifo_rd_d  = fifo_rd_q + PTR_ONE;
            fifo_cnt_d = fifo_cnt_d - CNT_ONE;
        end

        if (redirect_valid) begin
            // Everything still outstanding after this cycle becomes stale
            drop_d     = inflight_d;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            fifo_cnt_d = '0;
            fifo_rd_d  = fifo_wr_d;
        end
    end

    // Counter, pointer and PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // PC tag queue for requests awaiting their response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem_q[PTR_W'(i)] <= '0;
            end
        end else if (req_fire) begin
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
        end
    end

    // Instruction buffer storage; cleared on reset so inst/inst_pc read zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[PTR_W'(i)] <= '0;
            end
        end else if (fifo_push) begin
            fifo_mem_q[fifo_wr_q] <= '{pc: tag_mem_q[tag_rd_q], word: imem_rsp_data};
        end
    end

endmodule
